uart_tx_scheduler: RTL and testbench

Shares one UART transmit line between several byte requesters. The block runs round-robin arbitration, latches the granted byte, and serialises it as an 8N1 frame (LSB first). Bit timing comes from an internal single-clock-domain baud tick counter, so no toggled divided clock is used. It sits between the on-chip byte producers and the FPGA TX pin, and replaces direct use of a divided baud clock for transmission.

---
 rtl/uart_tx_scheduler_if.sv | 25 ++
 rtl/uart_tx_scheduler.sv | 115 +++++++++++
 tb/tb_uart_tx_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Byte-requester bus and serial-line outputs of the UART TX scheduler.
// master: the side that offers bytes and watches the line; slave: the scheduler.
interface uart_tx_scheduler_if #(
  parameter int NREQ = 4
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx;
  logic              busy;
  logic [GW-1:0]     grant_id;
  logic              done;

  modport master (
    output req_valid, req_data,
    input  req_ready, tx, busy, grant_id, done
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, tx, busy, grant_id, done
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter in front of an 8N1 UART serialiser. Bit timing is an
// enable-style baud counter in the clk domain; no divided clock is produced.
//
// Handshake: requester i transfers its byte in a cycle where
// req_valid[i] && req_ready[i]. A requester holds valid/data stable until
// accepted (it may withdraw valid instead); req_ready is only ever raised in
// IDLE, for the single round-robin winner, and never while rst is high.
module uart_tx_scheduler #(
  parameter int NREQ    = 4,
  parameter int DIVISOR = 10000
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_scheduler_if.slave  bus,
  output logic [1:0]          state_dbg
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] grant;
  logic          boundary;
  logic          found;
  logic [GW-1:0] pick;
  logic          hs;
  int            rr_idx;

  assign boundary = (baud == BW'(DIVISOR - 1));

  // Round-robin search: first valid requester after the last grant, wrapping.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      rr_idx = int'(last_grant) + 1 + i;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      if (!found && bus.req_valid[GW'(rr_idx)]) begin
        found = 1'b1;
        pick  = GW'(rr_idx);
      end
    end
  end

  // Acceptance happens only from IDLE and is suppressed while reset is held.
  assign hs = (state == IDLE) && found && !rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: each non-idle state lasts whole bit periods.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = START;
      START:   if (boundary) state_nxt = DATA;
      DATA:    if (boundary && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    if (boundary) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: byte latch, baud/bit counters and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      last_grant <= GW'(NREQ - 1);
      grant      <= '0;
    end else if (hs) begin
      baud       <= '0;
      bit_cnt    <= '0;
      shift      <= bus.req_data[{pick, 3'b000} +: 8];
      last_grant <= pick;
      grant      <= pick;
    end else if (state != IDLE) begin
      baud <= boundary ? '0 : baud + 1'b1;
      if (state == DATA && boundary) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Outputs decoded from state; tx idles high outside START/DATA.
  always_comb begin
    bus.req_ready       = '0;
    bus.req_ready[pick] = hs;
    bus.busy            = (state != IDLE);
    bus.done            = (state == STOP) && boundary;
    bus.grant_id        = grant;
    state_dbg           = state;
    case (state)
      START:   bus.tx = 1'b0;
      DATA:    bus.tx = shift[0];
      default: bus.tx = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a frame-timeline reference model (cycles since
// handshake -> expected line level), per-requester byte FIFOs as drivers and
// a serial-decode scoreboard. A second instance covers DIVISOR=2.
module tb_uart_tx_scheduler;
  localparam int NREQ = 4;
  localparam int D    = 4;
  localparam int D2   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NREQ(NREQ)) bus ();
  uart_tx_scheduler_if #(.NREQ(NREQ)) bus2 ();
  logic [1:0] state_dbg;
  logic [1:0] state_dbg2;

  uart_tx_scheduler #(.NREQ(NREQ), .DIVISOR(D)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );
  uart_tx_scheduler #(.NREQ(NREQ), .DIVISOR(D2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .state_dbg(state_dbg2)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: m_t = cycles since handshake (0 = no frame in flight).
  int         m_t     = 0;
  int         m_last  = NREQ - 1;
  int         m_grant = 0;
  logic [7:0] m_byte  = 8'h00;
  logic [7:0] rx_sr   = 8'h00;
  logic [7:0] exp_q[$];

  // Per-requester pending bytes.
  logic [7:0]      f_mem[NREQ][128];
  int              f_hd[NREQ];
  int              f_tl[NREQ];
  logic [NREQ-1:0] gate        = '1;
  bit              random_gate = 1'b0;

  // Handshake log written by the model.
  int hs_cyc[256];
  int hs_id[256];
  int hs_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (f_hd[i] != f_tl[i] && gate[i]) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_data[8*i +: 8]  = f_mem[i][f_hd[i]];
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_data[8*i +: 8]  = 8'($urandom);
      end
    end
  endtask

  task automatic push(input int r, input logic [7:0] b);
    f_mem[r][f_tl[r]] = b;
    f_tl[r]++;
    drive();
  endtask

  // One clock cycle: check outputs at negedge, advance model, re-drive.
  task automatic step();
    int              pick;
    int              r;
    int              k;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_tx;
    logic            exp_busy;
    logic            exp_done;
    @(negedge clk);
    pick    = -1;
    exp_rdy = '0;
    if (m_t == 0) begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      if (!rst) begin
        for (int i = 0; i < NREQ; i++) begin
          r = (m_last + 1 + i) % NREQ;
          if (pick < 0 && bus.req_valid[r]) pick = r;
        end
      end
      if (pick >= 0) exp_rdy[pick] = 1'b1;
    end else begin
      exp_busy = 1'b1;
      exp_done = (m_t == 10 * D);
      if (m_t <= D) exp_tx = 1'b0;
      else if (m_t <= 9 * D) begin
        k      = (m_t - 1) / D - 1;
        exp_tx = m_byte[k];
      end else exp_tx = 1'b1;
    end
    chk("tx", bus.tx, exp_tx);
    chk("busy", bus.busy, exp_busy);
    chk("done", bus.done, exp_done);
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("grant_id", bus.grant_id, m_grant);

    // Serial scoreboard: sample mid-bit, compare whole byte at end of bit 7.
    if (m_t > D && m_t <= 9 * D && ((m_t - 1) % D) == D / 2) rx_sr = {bus.tx, rx_sr[7:1]};
    if (m_t == 9 * D && exp_q.size() > 0) chk("rx_byte", rx_sr, exp_q.pop_front());

    if (rst) begin
      m_t     = 0;
      m_last  = NREQ - 1;
      m_grant = 0;
      exp_q.delete();
    end else if (m_t > 0) begin
      m_t = (m_t == 10 * D) ? 0 : m_t + 1;
    end else if (pick >= 0) begin
      m_byte = f_mem[pick][f_hd[pick]];
      f_hd[pick]++;
      m_t     = 1;
      m_last  = pick;
      m_grant = pick;
      exp_q.push_back(m_byte);
      hs_cyc[hs_n] = cyc;
      hs_id[hs_n]  = pick;
      hs_n++;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (random_gate) gate = NREQ'($urandom);
    drive();
  endtask

  task automatic run_hs(input int target, input int budget);
    int n = 0;
    while (hs_n < target && n < budget) begin
      step();
      n++;
    end
    chk("hs_wait", hs_n, target);
  endtask

  task automatic run_idle(input int budget);
    int  n = 0;
    bit  pending = 1'b1;
    while (pending && n < budget) begin
      step();
      n++;
      pending = (m_t != 0);
      for (int i = 0; i < NREQ; i++) if (f_hd[i] != f_tl[i]) pending = 1'b1;
    end
    chk("idle_wait", {31'b0, pending}, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int         base;
    int         n;
    logic       exp_b;
    logic [7:0] b2;
    for (int i = 0; i < NREQ; i++) begin
      f_hd[i] = 0;
      f_tl[i] = 0;
    end
    bus2.req_valid = '0;
    bus2.req_data  = '0;
    drive();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst2_tx", bus2.tx, 1);
    chk("rst2_busy", bus2.busy, 0);
    rst = 1'b0;
    step();

    // Single byte 0x55 from requester 0.
    base = hs_n;
    push(0, 8'h55);
    run_hs(base + 1, 10);
    chk("single_id", hs_id[base], 0);
    run_idle(100);

    // All four valid coming out of reset.
    rst = 1'b1;
    push(0, 8'h00);
    push(1, 8'hFF);
    push(2, 8'hA5);
    push(3, 8'h3C);
    step();
    rst = 1'b0;
    base = hs_n;
    run_hs(base + 4, 300);
    for (int i = 0; i < 4; i++) chk("rr4_id", hs_id[base + i], i);
    for (int i = 0; i < 3; i++) chk("rr4_gap", hs_cyc[base + i + 1] - hs_cyc[base + i], 10 * D + 1);
    run_idle(100);

    // Requesters 1 and 3 busy; requester 2 joins after the second grant.
    base = hs_n;
    push(1, 8'h11);
    push(1, 8'h12);
    push(3, 8'h31);
    push(3, 8'h32);
    run_hs(base + 2, 200);
    push(2, 8'h21);
    run_hs(base + 5, 400);
    chk("rr_a", hs_id[base + 0], 1);
    chk("rr_b", hs_id[base + 1], 3);
    chk("rr_c", hs_id[base + 2], 1);
    chk("rr_d", hs_id[base + 3], 2);
    chk("rr_e", hs_id[base + 4], 3);

    // Wrap: after grant 3 only requester 0 waits.
    push(0, 8'h0F);
    run_hs(base + 6, 200);
    chk("wrap_id", hs_id[base + 5], 0);
    chk("wrap_gap", hs_cyc[base + 5] - hs_cyc[base + 4], 10 * D + 1);
    chk("wrap_grant", bus.grant_id, 0);
    run_idle(100);

    // Reset in the middle of data bit 5; pointer must return to requester 0.
    base = hs_n;
    push(1, 8'hC3);
    run_hs(base + 1, 10);
    n = 0;
    while (m_t != 6 * D + 2 && n < 100) begin
      step();
      n++;
    end
    chk("bit5_wait", m_t, 6 * D + 2);
    push(2, 8'h2A);
    push(0, 8'h0A);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", bus.tx, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_grant", bus.grant_id, 0);
    run_hs(base + 2, 20);
    chk("post_rst_id", hs_id[base + 1], 0);
    run_idle(200);

    // Randomised traffic with valid withdrawn at random.
    random_gate = 1'b1;
    n = 0;
    for (int c = 0; c < 1500; c++) begin
      if (n < 40 && $urandom_range(0, 15) == 0) begin
        push($urandom_range(0, NREQ - 1), 8'($urandom));
        n++;
      end
      step();
    end
    random_gate = 1'b0;
    gate = '1;
    drive();
    run_idle(3000);

    // DIVISOR=2: single byte 0x80 on the second instance.
    b2 = 8'h80;
    bus2.req_data[7:0] = b2;
    bus2.req_valid[0]  = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus2.req_ready[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("d2_ready", bus2.req_ready, 4'b0001);
    @(posedge clk);
    #1;
    bus2.req_valid = '0;
    for (int t = 1; t <= 21; t++) begin
      @(negedge clk);
      if (t <= D2) exp_b = 1'b0;
      else if (t <= 9 * D2) exp_b = b2[(t - 1) / D2 - 1];
      else exp_b = 1'b1;
      chk("d2_tx", bus2.tx, exp_b);
      chk("d2_busy", bus2.busy, (t <= 10 * D2) ? 1 : 0);
      chk("d2_done", bus2.done, (t == 10 * D2) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
